// File: rtl/spart_pkg.sv
// Shared SPART definitions: receiver state encoding, oversampling ratio and bus register map.
package spart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } rx_state_t;

  localparam int OVERSAMPLE = 16;

  localparam logic [1:0] ADDR_DATA = 2'b00;
  localparam logic [1:0] ADDR_STAT = 2'b01;
  localparam logic [1:0] ADDR_DBL  = 2'b10;
  localparam logic [1:0] ADDR_DBH  = 2'b11;

endpackage

// File: rtl/spart_rx_if.sv
// Receiver-side signal bundle: serial line, baud enable, bus read strobe and status/data outputs.
interface spart_rx_if #(
  parameter int DATA_BITS = 8
);
  logic                 rxd;
  logic                 brg_tick;
  logic                 rd_ack;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rda;
  logic                 fe;
  logic                 oe;

  // Receiver side
  modport slave (
    input  rxd, brg_tick, rd_ack,
    output rx_data, rda, fe, oe
  );

  // Bus / line side
  modport master (
    output rxd, brg_tick, rd_ack,
    input  rx_data, rda, fe, oe
  );
endinterface

// File: rtl/spart_sync.sv
// Multi-flop synchroniser for an asynchronous single-bit input, with a selectable reset level.
module spart_sync #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] stage_reg;

  // Shift the input through the flop chain; the oldest stage is the synchronised output
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stage_reg <= {STAGES{RESET_VAL}};
    else        stage_reg <= {stage_reg[STAGES-2:0], d};
  end

  assign q = stage_reg[STAGES-1];

endmodule

// File: rtl/spart_rx.sv
// SPART receiver: 16x-oversampled 8N1 deserialiser with data-available, framing and overrun flags.
module spart_rx
  import spart_pkg::*;
#(
  parameter int DATA_BITS   = 8,
  parameter int OVERSAMPLE  = spart_pkg::OVERSAMPLE,
  parameter int SYNC_STAGES = 2
) (
  input logic        clk,
  input logic        rst_n,
  spart_rx_if.slave  bus
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

  logic                 rxd_s;
  rx_state_t            state;
  logic [TW-1:0]        tick_cnt;
  logic [BW-1:0]        bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic [DATA_BITS-1:0] rx_data_reg;
  logic                 rda_reg;
  logic                 fe_reg;
  logic                 oe_reg;
  logic                 complete;

  spart_sync #(
    .STAGES    (SYNC_STAGES),
    .RESET_VAL (1'b1)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (bus.rxd),
    .q     (rxd_s)
  );

  // Stop-bit sample instant: the frame is handed to the output registers on this clock
  assign complete = bus.brg_tick && (state == STOP) && (tick_cnt == TICK_LAST);

  // Frame FSM: advances only on baud ticks, counters cleared on every state entry
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      tick_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
    end else if (bus.brg_tick) begin
      case (state)
        IDLE: begin
          if (!rxd_s) begin
            state    <= START;
            tick_cnt <= '0;
            bit_cnt  <= '0;
          end
        end
        START: begin
          if (tick_cnt == TICK_MID) begin
            // A line that is high again at mid start bit was only a glitch
            state    <= rxd_s ? IDLE : DATA;
            tick_cnt <= '0;
            bit_cnt  <= '0;
          end else begin
            tick_cnt <= tick_cnt + TW'(1);
          end
        end
        DATA: begin
          if (tick_cnt == TICK_LAST) begin
            // LSB arrives first, so shift in from the top
            shreg    <= {rxd_s, shreg[DATA_BITS-1:1]};
            tick_cnt <= '0;
            if (bit_cnt == BIT_LAST) begin
              state   <= STOP;
              bit_cnt <= '0;
            end else begin
              bit_cnt <= bit_cnt + BW'(1);
            end
          end else begin
            tick_cnt <= tick_cnt + TW'(1);
          end
        end
        STOP: begin
          if (tick_cnt == TICK_LAST) begin
            // A low stop bit means the line may be in break; wait for idle before rearming
            state    <= rxd_s ? IDLE : BREAK;
            tick_cnt <= '0;
            bit_cnt  <= '0;
          end else begin
            tick_cnt <= tick_cnt + TW'(1);
          end
        end
        BREAK: begin
          if (rxd_s) begin
            state    <= IDLE;
            tick_cnt <= '0;
            bit_cnt  <= '0;
          end
        end
        default: begin
          state    <= IDLE;
          tick_cnt <= '0;
          bit_cnt  <= '0;
        end
      endcase
    end
  end

  // Output registers: completion has priority over a coincident bus read
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_data_reg <= '0;
      rda_reg     <= 1'b0;
      fe_reg      <= 1'b0;
      oe_reg      <= 1'b0;
    end else if (complete) begin
      rx_data_reg <= shreg;
      rda_reg     <= 1'b1;
      fe_reg      <= ~rxd_s;
      oe_reg      <= rda_reg & ~bus.rd_ack;
    end else if (bus.rd_ack) begin
      rda_reg <= 1'b0;
      fe_reg  <= 1'b0;
      oe_reg  <= 1'b0;
    end
  end

  assign bus.rx_data = rx_data_reg;
  assign bus.rda     = rda_reg;
  assign bus.fe      = fe_reg;
  assign bus.oe      = oe_reg;

endmodule

// File: tb/tb_spart_rx.sv
// Self-checking bench for spart_rx: directed scenarios plus randomized frames against a frame-level model.
module tb_spart_rx;
  import spart_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  spart_rx_if #(.DATA_BITS(8)) bus ();

  spart_rx #(
    .DATA_BITS   (8),
    .OVERSAMPLE  (16),
    .SYNC_STAGES (2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  // 50 MHz
  always #10 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: what the status/data registers should show, updated per frame event
  logic [7:0] m_data;
  logic       m_rda, m_fe, m_oe;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".rda"},  32'(bus.rda),     32'(m_rda));
    chk({tag, ".data"}, 32'(bus.rx_data), 32'(m_data));
    chk({tag, ".fe"},   32'(bus.fe),      32'(m_fe));
    chk({tag, ".oe"},   32'(bus.oe),      32'(m_oe));
  endtask

  task automatic model_reset();
    m_data = 8'h00; m_rda = 1'b0; m_fe = 1'b0; m_oe = 1'b0;
  endtask

  task automatic model_frame(input logic [7:0] b, input logic stop, input logic ack);
    m_oe   = m_rda & ~ack;
    m_rda  = 1'b1;
    m_fe   = ~stop;
    m_data = b;
  endtask

  task automatic model_ack();
    m_rda = 1'b0; m_fe = 1'b0; m_oe = 1'b0;
  endtask

  // One clock: inputs applied just after an edge, held through the next edge
  task automatic cyc(input logic tick, input logic ack);
    bus.brg_tick = tick;
    bus.rd_ack   = ack;
    @(posedge clk);
    #1;
    bus.brg_tick = 1'b0;
    bus.rd_ack   = 1'b0;
  endtask

  // One baud tick period (20 clk), tick in the first clock
  task automatic period();
    cyc(1'b1, 1'b0);
    repeat (19) cyc(1'b0, 1'b0);
  endtask

  task automatic idle_periods(input int n);
    for (int i = 0; i < n; i++) period();
  endtask

  // Line level in tick period p of an 8N1 frame: 16 ticks per bit
  function automatic logic line_level(input logic [7:0] b, input logic stop, input int p);
    int idx;
    if (p < 16) return 1'b0;
    if (p < 144) begin
      idx = (p - 16) / 16;
      return b[idx];
    end
    return stop;
  endfunction

  task automatic bus_read(input string tag);
    cyc(1'b0, 1'b1);
    model_ack();
    $display("read  %s", tag);
    check_all(tag);
  endtask

  // Drive a full frame; the stop bit is sampled on the tick of period 153 after the start edge
  task automatic send_frame(input string tag, input logic [7:0] b, input logic stop, input logic ack_done);
    for (int p = 0; p < 160; p++) begin
      bus.rxd = line_level(b, stop, p);
      if (p == 153) begin
        chk({tag, ".pre_rda"}, 32'(bus.rda), 32'(m_rda));
        cyc(1'b1, ack_done);
        model_frame(b, stop, ack_done);
        $display("frame %s data=%02h stop=%0d ack=%0d", tag, b, stop, ack_done);
        check_all(tag);
        repeat (19) cyc(1'b0, 1'b0);
      end else begin
        period();
      end
    end
  endtask

  initial begin
    logic [7:0] b;
    logic       stop, ack;
    int         len;

    bus.rxd = 1'b1; bus.brg_tick = 1'b0; bus.rd_ack = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_all("reset");
    rst_n = 1'b1;
    idle_periods(3);

    // 1: basic frame then bus read
    send_frame("t1", 8'h48, 1'b1, 1'b0);
    idle_periods(2);
    bus_read("t1_read");

    // 2: short low glitch rejected, then a real frame
    len = $urandom_range(1, 7);
    bus.rxd = 1'b0;
    idle_periods(len);
    bus.rxd = 1'b1;
    idle_periods(20);
    $display("glitch len=%0d ticks", len);
    check_all("t2_glitch");
    send_frame("t2", 8'h65, 1'b1, 1'b0);
    idle_periods(2);
    bus_read("t2_read");

    // 3: framing error, line held low afterwards without producing a phantom frame
    send_frame("t3", 8'h6C, 1'b0, 1'b0);
    idle_periods(32);
    check_all("t3_brk2");
    idle_periods(170);
    check_all("t3_brk_long");
    bus.rxd = 1'b1;
    idle_periods(4);
    check_all("t3_idle");
    bus_read("t3_read");

    // 4: overrun
    send_frame("t4a", 8'h6F, 1'b1, 1'b0);
    idle_periods(2);
    send_frame("t4b", 8'h21, 1'b1, 1'b0);
    idle_periods(2);
    bus_read("t4_read");

    // 5: read coinciding with completion while the previous byte is still unread
    send_frame("t5a", 8'($urandom_range(0, 255)), 1'b1, 1'b0);
    idle_periods(2);
    send_frame("t5b", 8'h55, 1'b1, 1'b1);
    idle_periods(2);

    // 6: asynchronous reset in the middle of the data bits
    for (int p = 0; p < 60; p++) begin
      bus.rxd = line_level(8'hC3, 1'b1, p);
      period();
    end
    #3 rst_n = 1'b0;
    model_reset();
    #2;
    $display("reset mid-frame");
    check_all("t6_rst");
    bus.rxd = 1'b1;
    #20 rst_n = 1'b1;
    @(posedge clk);
    #1;
    idle_periods(3);
    check_all("t6_after");
    send_frame("t6", 8'hA5, 1'b1, 1'b0);
    idle_periods(2);

    // Randomized frames with random reads, framing errors and read-on-completion
    for (int n = 0; n < 8; n++) begin
      if ($urandom_range(0, 1) == 1) begin
        repeat ($urandom_range(0, 15)) cyc(1'b0, 1'b0);
        bus_read("rnd_read");
        idle_periods(1);
      end
      b    = 8'($urandom_range(0, 255));
      stop = ($urandom_range(0, 3) != 0);
      ack  = 1'($urandom_range(0, 1));
      send_frame("rnd", b, stop, ack);
      bus.rxd = 1'b1;
      idle_periods($urandom_range(1, 3));
      check_all("rnd_idle");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
